bp_me_cce_mem_arbiter: RTL and testbench
========================================

// Module: bp_me_cce_mem_arbiter
// PURPOSE
// - Upstream of the CCE-to-cache converter: merges num_src_p CCE memory command streams into one
//   command stream for the converter, and routes responses back to the issuing source in order.
// - Responses return in command order, so a FIFO of source IDs replaces any per-message tagging.
// PARAMETERS
// - num_src_p        2   number of CCE command sources (>=2)
// - msg_width_p      -   width of one cce mem message (header+data), from declare_bp_me_if widths
// - outstanding_p    4   max commands issued to downstream whose response has not returned
// PORTS
// - clk_i            in   1                    clock
// - reset_i          in   1                    synchronous, active-high reset
// - mem_cmd_i        in   num_src_p*msg_w      per-source command message
// - mem_cmd_v_i      in   num_src_p            per-source command valid
// - mem_cmd_ready_o  out  num_src_p            per-source ready (ready/valid; xfer = v&ready)
// - mem_cmd_o        out  msg_w                merged command to converter
// - mem_cmd_v_o      out  1                    merged command valid
// - mem_cmd_ready_i  in   1                    converter ready (ready/valid)
// - mem_resp_i       in   msg_w                response from converter
// - mem_resp_v_i     in   1                    response valid
// - mem_resp_yumi_o  out  1                    response consumed (valid->yumi)
// - mem_resp_o       out  num_src_p*msg_w      per-source response (mem_resp_i broadcast)
// - mem_resp_v_o     out  num_src_p            per-source response valid (one-hot or zero)
// - mem_resp_yumi_i  in   num_src_p            per-source response yumi
// BEHAVIOUR
// - Clock clk_i; reset_i synchronous, active-high. While reset_i=1: all *_v_o, mem_cmd_ready_o,
//   mem_resp_yumi_o = 0; all FIFOs emptied; rr pointer last_r = num_src_p-1 (src 0 wins first).
// - Reset mid-operation discards all buffered commands and pending IDs; no output asserted next cycle.
// - Input stage: one 2-entry FIFO per source; mem_cmd_ready_o[i] = FIFO i not full; no bypass,
//   so a command accepted in cycle t can appear on mem_cmd_o at t+1 at the earliest.
// - Arbitration: among non-empty input FIFOs, grant first index scanning last_r+1, last_r+2, ...
//   modulo num_src_p. mem_cmd_v_o = any_valid & ~id_fifo_full; mem_cmd_o = head of granted FIFO.
// - Handshake: xfer = mem_cmd_v_o & mem_cmd_ready_i -> dequeue granted FIFO, enqueue grant index
//   into ID FIFO (outstanding_p entries), last_r <= grant. No xfer -> last_r unchanged; grant may
//   change while v_o held (downstream is ready/valid, not yumi).
// - ID FIFO full: mem_cmd_v_o = 0 even if sources valid; enqueue and dequeue in the same cycle
//   are both performed when not full; when full, dequeue this cycle frees a slot next cycle only.
// - Response route: h = ID FIFO head. mem_resp_v_o[h] = mem_resp_v_i & id_fifo_v; others 0.
//   mem_resp_yumi_o = mem_resp_yumi_i[h] & mem_resp_v_o[h]; on yumi dequeue ID FIFO. Zero latency.
// - mem_resp_v_i with empty ID FIFO: protocol error; mem_resp_yumi_o = 0, response held; a
//   simulation-only assertion fires. mem_resp_yumi_i[j] for j != h is ignored.
// - Width rules: grant/ID width = BSG_SAFE_CLOG2(num_src_p); rr wrap via explicit compare, not
//   power-of-two masking; outstanding count never exceeds outstanding_p.
// CONFIGURATION
// - BP_ME_CCE_MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index with a valid head wins;
//   last_r not instantiated. Undefined (default): round-robin as above. Routing unaffected.
// TESTING
// - Reset, then src0 sends 1 cmd at cycle 0, ready_i=1 -> mem_cmd_v_o=1 at cycle 1, ID FIFO = {0}.
// - src0,src1 both stream 4 cmds, ready_i=1 -> output order 0,1,0,1,0,1,0,1 (FIXED_PRIO: 0x4,1x4).
// - ready_i=0 for 6 cycles with both valid -> inputs stall after 2 accepts each, nothing lost.
// - Issue 4 cmds, no responses -> 5th blocked (mem_cmd_v_o=0); 1 resp yumi'd -> 5th issues next cycle.
// - Resps for IDs {1,0,1}: mem_resp_v_o = 2'b10,2'b01,2'b10; yumi_i[0] during 2'b10 -> no dequeue.
// - reset_i pulsed with 3 outstanding + buffered cmds -> all v_o=0 next cycle; src0 wins first grant.

Source files
------------

// File: rtl/bp_me_cce_mem_arbiter.sv
// bp_me_cce_mem_arbiter
// Merges num_src_p CCE memory command streams into one stream for the
// CCE-to-cache converter. Responses come back in command order, so a FIFO of
// source IDs routes each response to the source that issued it.
// Optional build macro BP_ME_CCE_MEM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of the default round-robin arbitration.
module bp_me_cce_mem_arbiter #(
    parameter int num_src_p     = 2,
    parameter int msg_width_p   = 16,
    parameter int outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_src_p*msg_width_p-1:0] mem_cmd_i,
    input  logic [num_src_p-1:0]             mem_cmd_v_i,
    output logic [num_src_p-1:0]             mem_cmd_ready_o,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic [num_src_p*msg_width_p-1:0] mem_resp_o,
    output logic [num_src_p-1:0]             mem_resp_v_o,
    input  logic [num_src_p-1:0]             mem_resp_yumi_i
);

    localparam int id_w  = (num_src_p <= 1) ? 1 : $clog2(num_src_p);
    localparam int ptr_w = (outstanding_p <= 1) ? 1 : $clog2(outstanding_p);
    localparam int cnt_w = $clog2(outstanding_p + 1);

    // two-entry input FIFO per source
    logic [msg_width_p-1:0] buf_mem [num_src_p][2];
    logic [num_src_p-1:0]   buf_wptr, buf_rptr;
    logic [1:0]             buf_cnt [num_src_p];
    logic [num_src_p-1:0]   buf_full, buf_nonempty, buf_enq, buf_deq;

    // ID FIFO of granted source indices, one entry per outstanding command
    logic [id_w-1:0]  id_mem [outstanding_p];
    logic [ptr_w-1:0] id_wptr, id_rptr;
    logic [cnt_w-1:0] id_cnt;
    logic             id_v, id_full, id_enq, id_deq;

    logic [id_w-1:0] grant, head;
    logic            any_valid, xfer;

    // per-source FIFO status and dequeue selects
    always_comb begin
        buf_full     = '0;
        buf_nonempty = '0;
        buf_deq      = '0;
        for (int i = 0; i < num_src_p; i++) begin
            buf_full[i]     = (buf_cnt[i] == 2'd2);
            buf_nonempty[i] = (buf_cnt[i] != 2'd0);
            buf_deq[i]      = xfer && (grant == id_w'(i));
        end
    end

    assign id_v    = (id_cnt != '0);
    assign id_full = (id_cnt == cnt_w'(outstanding_p));

    // everything facing the outside is forced low while reset is held
    assign mem_cmd_ready_o = reset_i ? '0 : ~buf_full;
    assign buf_enq         = mem_cmd_v_i & mem_cmd_ready_o;
    assign mem_cmd_v_o     = ~reset_i & any_valid & ~id_full;
    assign xfer            = mem_cmd_v_o & mem_cmd_ready_i;
    assign mem_cmd_o       = buf_mem[grant][buf_rptr[grant]];

`ifdef BP_ME_CCE_MEM_ARB_FIXED_PRIO_EN
    // fixed priority: lowest index with a buffered command wins
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int i = num_src_p - 1; i >= 0; i--) begin
            if (buf_nonempty[i]) begin
                grant     = id_w'(i);
                any_valid = 1'b1;
            end
        end
    end
`else
    logic [id_w-1:0] last_r, grant_hi, grant_lo;
    logic            found_hi;

    // round-robin: lowest index above last_r, else wrap to lowest index overall
    always_comb begin
        grant_lo  = '0;
        grant_hi  = '0;
        found_hi  = 1'b0;
        any_valid = 1'b0;
        for (int i = num_src_p - 1; i >= 0; i--) begin
            if (buf_nonempty[i]) begin
                grant_lo  = id_w'(i);
                any_valid = 1'b1;
                if (id_w'(i) > last_r) begin
                    grant_hi = id_w'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    // pointer only moves on an accepted transfer
    always_ff @(posedge clk_i) begin
        if (reset_i)
            last_r <= id_w'(num_src_p - 1);
        else if (xfer)
            last_r <= grant;
    end
`endif

    // input FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_src_p; i++) begin
            if (reset_i) begin
                buf_wptr[i] <= 1'b0;
                buf_rptr[i] <= 1'b0;
                buf_cnt[i]  <= 2'd0;
            end else begin
                if (buf_enq[i]) buf_wptr[i] <= ~buf_wptr[i];
                if (buf_deq[i]) buf_rptr[i] <= ~buf_rptr[i];
                case ({buf_enq[i], buf_deq[i]})
                    2'b10:   buf_cnt[i] <= buf_cnt[i] + 2'd1;
                    2'b01:   buf_cnt[i] <= buf_cnt[i] - 2'd1;
                    default: buf_cnt[i] <= buf_cnt[i];
                endcase
            end
        end
    end

    // input FIFO storage
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_src_p; i++) begin
            if (buf_enq[i])
                buf_mem[i][buf_wptr[i]] <= mem_cmd_i[i*msg_width_p +: msg_width_p];
        end
    end

    assign id_enq = xfer;
    assign id_deq = mem_resp_yumi_o;
    assign head   = id_mem[id_rptr];

    // ID FIFO pointers and occupancy; wrap by compare so any depth works
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            id_wptr <= '0;
            id_rptr <= '0;
            id_cnt  <= '0;
        end else begin
            if (id_enq)
                id_wptr <= (id_wptr == ptr_w'(outstanding_p - 1)) ? '0 : id_wptr + 1'b1;
            if (id_deq)
                id_rptr <= (id_rptr == ptr_w'(outstanding_p - 1)) ? '0 : id_rptr + 1'b1;
            case ({id_enq, id_deq})
                2'b10:   id_cnt <= id_cnt + 1'b1;
                2'b01:   id_cnt <= id_cnt - 1'b1;
                default: id_cnt <= id_cnt;
            endcase
        end
    end

    // ID FIFO storage
    always_ff @(posedge clk_i) begin
        if (id_enq)
            id_mem[id_wptr] <= grant;
    end

    // response goes only to the source at the head of the ID FIFO
    always_comb begin
        mem_resp_v_o = '0;
        for (int i = 0; i < num_src_p; i++)
            mem_resp_v_o[i] = ~reset_i & mem_resp_v_i & id_v & (head == id_w'(i));
    end

    assign mem_resp_yumi_o = |(mem_resp_v_o & mem_resp_yumi_i);
    assign mem_resp_o      = {num_src_p{mem_resp_i}};

`ifndef SYNTHESIS
    // a response with nothing outstanding is a protocol error upstream
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(mem_resp_v_i && !id_v));
    end
`endif

endmodule

// File: tb/tb_bp_me_cce_mem_arbiter.sv
// Bench for bp_me_cce_mem_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_bp_me_cce_mem_arbiter;

    localparam int N   = 2;
    localparam int W   = 16;
    localparam int OUT = 4;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [N*W-1:0]   cmd_i;
    logic [N-1:0]     cmd_v_i, cmd_ready_o;
    logic [W-1:0]     cmd_o;
    logic             cmd_v_o, cmd_ready_i;
    logic [W-1:0]     resp_i;
    logic             resp_v_i, resp_yumi_o;
    logic [N*W-1:0]   resp_o;
    logic [N-1:0]     resp_v_o, resp_yumi_i;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bp_me_cce_mem_arbiter #(
        .num_src_p    (N),
        .msg_width_p  (W),
        .outstanding_p(OUT)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .mem_cmd_i      (cmd_i),
        .mem_cmd_v_i    (cmd_v_i),
        .mem_cmd_ready_o(cmd_ready_o),
        .mem_cmd_o      (cmd_o),
        .mem_cmd_v_o    (cmd_v_o),
        .mem_cmd_ready_i(cmd_ready_i),
        .mem_resp_i     (resp_i),
        .mem_resp_v_i   (resp_v_i),
        .mem_resp_yumi_o(resp_yumi_o),
        .mem_resp_o     (resp_o),
        .mem_resp_v_o   (resp_v_o),
        .mem_resp_yumi_i(resp_yumi_i)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] m_cmd_q [N][$];
    int           m_id_q [$];
    int           m_last;

    logic [N-1:0] e_ready, e_resp_v;
    logic         e_cmd_v, e_yumi;
    logic [W-1:0] e_cmd;
    int           e_grant;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_cmd_q[i].delete();
        m_id_q.delete();
        m_last = N - 1;
    endfunction

    function automatic void m_predict();
        e_ready  = '0;
        e_resp_v = '0;
        e_cmd_v  = 1'b0;
        e_yumi   = 1'b0;
        e_cmd    = '0;
        e_grant  = -1;
        if (reset_i) return;
        for (int i = 0; i < N; i++) e_ready[i] = (m_cmd_q[i].size() < 2);
`ifdef BP_ME_CCE_MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++)
            if (e_grant < 0 && m_cmd_q[k].size() > 0) e_grant = k;
`else
        for (int k = 1; k <= N; k++) begin
            int s;
            s = (m_last + k) % N;
            if (e_grant < 0 && m_cmd_q[s].size() > 0) e_grant = s;
        end
`endif
        if (e_grant >= 0 && m_id_q.size() < OUT) begin
            e_cmd_v = 1'b1;
            e_cmd   = m_cmd_q[e_grant][0];
        end
        if (resp_v_i && m_id_q.size() > 0) begin
            e_resp_v[m_id_q[0]] = 1'b1;
            e_yumi = resp_yumi_i[m_id_q[0]];
        end
    endfunction

    function automatic void m_step();
        if (reset_i) begin
            m_reset();
            return;
        end
        if (e_cmd_v && cmd_ready_i) begin
            void'(m_cmd_q[e_grant].pop_front());
            m_id_q.push_back(e_grant);
            m_last = e_grant;
        end
        if (e_yumi) void'(m_id_q.pop_front());
        for (int i = 0; i < N; i++)
            if (cmd_v_i[i] && e_ready[i]) m_cmd_q[i].push_back(cmd_i[i*W +: W]);
    endfunction

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        cmd_v_i     = '0;
        cmd_i       = '0;
        cmd_ready_i = 1'b0;
        resp_v_i    = 1'b0;
        resp_i      = '0;
        resp_yumi_i = '0;
        cyc();
        reset_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i     = 1'b1;
        cmd_v_i     = 2'b11;
        cmd_i       = 32'h1111_2222;
        cmd_ready_i = 1'b1;
        resp_v_i    = 1'b1;
        resp_yumi_i = 2'b11;
        cyc();
        cyc();
        #1;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL reset_cmd_v: got %b want 0", cmd_v_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 2'b00) $display("FAIL reset_ready: got %b want 00", cmd_ready_o); else n_pass++;
        n_checks++; if (resp_v_o !== 2'b00) $display("FAIL reset_resp_v: got %b want 00", resp_v_o); else n_pass++;
        n_checks++; if (resp_yumi_o !== 1'b0) $display("FAIL reset_yumi: got %b want 0", resp_yumi_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_single();
        cmd_i       = {16'h0000, 16'h00A5};
        cmd_v_i     = 2'b01;
        cmd_ready_i = 1'b1;
        #1;
        n_checks++; if (cmd_ready_o !== 2'b11) $display("FAIL single_ready: got %b want 11", cmd_ready_o); else n_pass++;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL single_no_bypass: got %b want 0", cmd_v_o); else n_pass++;
        cyc();
        cmd_v_i = 2'b00;
        #1;
        n_checks++; if (cmd_v_o !== 1'b1) $display("FAIL single_v_t1: got %b want 1", cmd_v_o); else n_pass++;
        n_checks++; if (cmd_o !== 16'h00A5) $display("FAIL single_data: got %h want 00a5", cmd_o); else n_pass++;
        cyc();
        #1;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL single_v_after: got %b want 0", cmd_v_o); else n_pass++;
        resp_i      = 16'hBEEF;
        resp_v_i    = 1'b1;
        resp_yumi_i = 2'b01;
        #1;
        n_checks++; if (resp_v_o !== 2'b01) $display("FAIL single_resp_v: got %b want 01", resp_v_o); else n_pass++;
        n_checks++; if (resp_yumi_o !== 1'b1) $display("FAIL single_yumi: got %b want 1", resp_yumi_o); else n_pass++;
        n_checks++; if (resp_o !== {2{16'hBEEF}}) $display("FAIL single_resp_data: got %h want beefbeef", resp_o); else n_pass++;
        cyc();
        resp_v_i    = 1'b0;
        resp_yumi_i = '0;
    endtask

    task automatic test_rr_order();
        int sent [N];
        int outstanding;
        logic [W-1:0] got [$];
        logic [W-1:0] exp_d, act_d;
        do_reset();
        sent[0] = 0;
        sent[1] = 0;
        outstanding = 0;
        for (int c = 0; c < 60 && got.size() < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                cmd_v_i[i]       = (sent[i] < 4);
                cmd_i[i*W +: W]  = {8'(i), 8'(sent[i])};
            end
            cmd_ready_i = 1'b1;
            resp_v_i    = (outstanding > 0);
            resp_yumi_i = 2'b11;
            #1;
            for (int i = 0; i < N; i++) if (cmd_v_i[i] && cmd_ready_o[i]) sent[i]++;
            if (cmd_v_o) begin
                got.push_back(cmd_o);
                outstanding++;
            end
            if (resp_yumi_o) outstanding--;
            cyc();
        end
        cmd_v_i = '0;
        for (int c = 0; c < 20 && outstanding > 0; c++) begin
            resp_v_i = 1'b1;
            #1;
            if (resp_yumi_o) outstanding--;
            cyc();
        end
        resp_v_i = 1'b0;
        n_checks++; if (got.size() !== 8) $display("FAIL rr_count: got %0d want 8", got.size()); else n_pass++;
        for (int k = 0; k < 8; k++) begin
`ifdef BP_ME_CCE_MEM_ARB_FIXED_PRIO_EN
            exp_d = {8'(k / 4), 8'(k % 4)};
`else
            exp_d = {8'(k % 2), 8'(k / 2)};
`endif
            act_d = (k < got.size()) ? got[k] : 'x;
            n_checks++; if (act_d !== exp_d) $display("FAIL rr_order[%0d]: got %h want %h", k, act_d, exp_d); else n_pass++;
        end
    endtask

    task automatic test_stall();
        int acc [N];
        logic [W-1:0] got [$];
        logic [W-1:0] expq [4];
        logic [W-1:0] act_d;
        do_reset();
        acc[0] = 0;
        acc[1] = 0;
        cmd_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cmd_v_i = 2'b11;
            for (int i = 0; i < N; i++) cmd_i[i*W +: W] = {8'(8'h10 + i), 8'(acc[i])};
            #1;
            for (int i = 0; i < N; i++) if (cmd_ready_o[i]) acc[i]++;
            cyc();
        end
        cmd_v_i = '0;
        #1;
        n_checks++; if (acc[0] !== 2) $display("FAIL stall_acc0: got %0d want 2", acc[0]); else n_pass++;
        n_checks++; if (acc[1] !== 2) $display("FAIL stall_acc1: got %0d want 2", acc[1]); else n_pass++;
        n_checks++; if (cmd_ready_o !== 2'b00) $display("FAIL stall_ready: got %b want 00", cmd_ready_o); else n_pass++;
        n_checks++; if (cmd_v_o !== 1'b1) $display("FAIL stall_v_held: got %b want 1", cmd_v_o); else n_pass++;
        cmd_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (cmd_v_o) got.push_back(cmd_o);
            cyc();
        end
`ifdef BP_ME_CCE_MEM_ARB_FIXED_PRIO_EN
        expq = '{16'h1000, 16'h1001, 16'h1100, 16'h1101};
`else
        expq = '{16'h1000, 16'h1100, 16'h1001, 16'h1101};
`endif
        n_checks++; if (got.size() !== 4) $display("FAIL stall_drain_count: got %0d want 4", got.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            act_d = (k < got.size()) ? got[k] : 'x;
            n_checks++; if (act_d !== expq[k]) $display("FAIL stall_drain[%0d]: got %h want %h", k, act_d, expq[k]); else n_pass++;
        end
    endtask

    // runs directly after test_stall: four commands outstanding, none answered
    task automatic test_outstanding();
        cmd_i   = {16'h0000, 16'h0077};
        cmd_v_i = 2'b01;
        #1;
        n_checks++; if (cmd_ready_o[0] !== 1'b1) $display("FAIL out_ready: got %b want 1", cmd_ready_o[0]); else n_pass++;
        cyc();
        cmd_v_i = '0;
        #1;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL out_blocked0: got %b want 0", cmd_v_o); else n_pass++;
        cyc();
        #1;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL out_blocked1: got %b want 0", cmd_v_o); else n_pass++;
        resp_v_i    = 1'b1;
        resp_yumi_i = 2'b11;
        #1;
        n_checks++; if (resp_yumi_o !== 1'b1) $display("FAIL out_yumi: got %b want 1", resp_yumi_o); else n_pass++;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL out_same_cycle: got %b want 0", cmd_v_o); else n_pass++;
        cyc();
        resp_v_i    = 1'b0;
        resp_yumi_i = '0;
        #1;
        n_checks++; if (cmd_v_o !== 1'b1) $display("FAIL out_fifth_v: got %b want 1", cmd_v_o); else n_pass++;
        n_checks++; if (cmd_o !== 16'h0077) $display("FAIL out_fifth_data: got %h want 0077", cmd_o); else n_pass++;
        cyc();
        do_reset();
    endtask

    task automatic test_resp_route();
        int ids [3];
        ids = '{1, 0, 1};
        do_reset();
        cmd_ready_i = 1'b1;
        cmd_i       = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            cmd_v_i = N'(1 << ids[k]);
            cyc();
            cmd_v_i = '0;
            cyc();
        end
        resp_i      = 16'h1234;
        resp_v_i    = 1'b1;
        resp_yumi_i = 2'b01;
        #1;
        n_checks++; if (resp_v_o !== 2'b10) $display("FAIL route_first: got %b want 10", resp_v_o); else n_pass++;
        n_checks++; if (resp_yumi_o !== 1'b0) $display("FAIL route_wrong_yumi: got %b want 0", resp_yumi_o); else n_pass++;
        cyc();
        #1;
        n_checks++; if (resp_v_o !== 2'b10) $display("FAIL route_held: got %b want 10", resp_v_o); else n_pass++;
        resp_yumi_i = 2'b10;
        #1;
        n_checks++; if (resp_yumi_o !== 1'b1) $display("FAIL route_yumi1: got %b want 1", resp_yumi_o); else n_pass++;
        cyc();
        resp_yumi_i = 2'b01;
        #1;
        n_checks++; if (resp_v_o !== 2'b01) $display("FAIL route_second: got %b want 01", resp_v_o); else n_pass++;
        n_checks++; if (resp_yumi_o !== 1'b1) $display("FAIL route_yumi2: got %b want 1", resp_yumi_o); else n_pass++;
        cyc();
        resp_yumi_i = 2'b10;
        #1;
        n_checks++; if (resp_v_o !== 2'b10) $display("FAIL route_third: got %b want 10", resp_v_o); else n_pass++;
        cyc();
        resp_v_i    = 1'b0;
        resp_yumi_i = '0;
        #1;
        n_checks++; if (resp_v_o !== 2'b00) $display("FAIL route_empty: got %b want 00", resp_v_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int issued;
        do_reset();
        issued      = 0;
        cmd_i       = 32'h2222_1111;
        cmd_ready_i = 1'b1;
        cmd_v_i     = 2'b11;
        for (int c = 0; c < 10 && issued < 3; c++) begin
            #1;
            if (cmd_v_o) issued++;
            cyc();
        end
        cmd_ready_i = 1'b0;
        cyc();
        cyc();
        reset_i     = 1'b1;
        resp_v_i    = 1'b1;
        resp_yumi_i = 2'b11;
        #1;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL mid_reset_cmd_v: got %b want 0", cmd_v_o); else n_pass++;
        n_checks++; if (resp_v_o !== 2'b00) $display("FAIL mid_reset_resp_v: got %b want 00", resp_v_o); else n_pass++;
        n_checks++; if (resp_yumi_o !== 1'b0) $display("FAIL mid_reset_yumi: got %b want 0", resp_yumi_o); else n_pass++;
        cyc();
        reset_i     = 1'b0;
        cmd_v_i     = '0;
        resp_v_i    = 1'b0;
        resp_yumi_i = '0;
        cmd_ready_i = 1'b1;
        #1;
        n_checks++; if (cmd_v_o !== 1'b0) $display("FAIL mid_discard: got %b want 0", cmd_v_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 2'b11) $display("FAIL mid_ready: got %b want 11", cmd_ready_o); else n_pass++;
        cmd_i   = {16'h00B1, 16'h00A0};
        cmd_v_i = 2'b11;
        cyc();
        cmd_v_i = '0;
        #1;
        n_checks++; if (cmd_v_o !== 1'b1) $display("FAIL mid_first_v: got %b want 1", cmd_v_o); else n_pass++;
        n_checks++; if (cmd_o !== 16'h00A0) $display("FAIL mid_first_grant: got %h want 00a0", cmd_o); else n_pass++;
        cyc();
        do_reset();
    endtask

    task automatic test_random();
        reset_i = 1'b1;
        m_predict();
        @(posedge clk);
        m_step();
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            reset_i     = ($urandom_range(99) == 0);
            cmd_v_i     = N'($urandom());
            cmd_i       = $urandom();
            cmd_ready_i = ($urandom_range(3) != 0);
            resp_i      = W'($urandom());
            resp_v_i    = (m_id_q.size() > 0) && ($urandom_range(1) == 1);
            resp_yumi_i = N'($urandom());
            #1;
            m_predict();
            n_checks++; if (cmd_v_o !== e_cmd_v) $display("FAIL rand_cmd_v c%0d: got %b want %b", c, cmd_v_o, e_cmd_v); else n_pass++;
            if (e_cmd_v) begin
                n_checks++; if (cmd_o !== e_cmd) $display("FAIL rand_cmd c%0d: got %h want %h", c, cmd_o, e_cmd); else n_pass++;
            end
            n_checks++; if (cmd_ready_o !== e_ready) $display("FAIL rand_ready c%0d: got %b want %b", c, cmd_ready_o, e_ready); else n_pass++;
            n_checks++; if (resp_v_o !== e_resp_v) $display("FAIL rand_resp_v c%0d: got %b want %b", c, resp_v_o, e_resp_v); else n_pass++;
            n_checks++; if (resp_yumi_o !== e_yumi) $display("FAIL rand_yumi c%0d: got %b want %b", c, resp_yumi_o, e_yumi); else n_pass++;
            n_checks++; if (resp_o !== {N{resp_i}}) $display("FAIL rand_resp_data c%0d: got %h want %h", c, resp_o, {N{resp_i}}); else n_pass++;
            @(posedge clk);
            m_step();
            @(negedge clk);
        end
        do_reset();
    endtask

    initial begin
        reset_i     = 1'b1;
        cmd_v_i     = '0;
        cmd_i       = '0;
        cmd_ready_i = 1'b0;
        resp_v_i    = 1'b0;
        resp_i      = '0;
        resp_yumi_i = '0;
        m_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_rr_order();
        test_stall();
        test_outstanding();
        test_resp_route();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
